// File: rtl/timer_arbiter_if.sv
// Bundle between the requesting clients / shared Timer and the timer_arbiter.
// The arbiter connects through the slave modport; the client/Timer side uses master.
interface timer_arbiter_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic [N-1:0]   req;
    logic [N-1:0]   req_up;
    logic [N*W-1:0] req_const;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [N-1:0]   err;
    logic           busy;
    logic           tmr_start;
    logic           tmr_up;
    logic [W-1:0]   tmr_const;
    logic           tmr_alarm;

    modport master (
        output req, req_up, req_const, tmr_alarm,
        input  grant, done, err, busy, tmr_start, tmr_up, tmr_const
    );

    modport slave (
        input  req, req_up, req_const, tmr_alarm,
        output grant, done, err, busy, tmr_start, tmr_up, tmr_const
    );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin sharing of one Timer among N requesters: START -> ARM -> RUN -> DONE per grant.
// Optional RUN watchdog enabled by defining TIMER_ARB_WATCHDOG_EN (err tied 0 otherwise).
module timer_arbiter #(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int WD_LIMIT = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    timer_arbiter_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_RUN,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [N-1:0]   done_q, done_d;
    logic           tmr_start_q, tmr_start_d;
    logic           tmr_up_q, tmr_up_d;
    logic [W-1:0]   tmr_const_q, tmr_const_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]  owner_q, owner_d;

    logic [IW-1:0]  cand [N];
    logic           found;
    logic [IW-1:0]  pick;
    logic [IW-1:0]  next_ptr;
    logic           owner_req;
    logic           wd_hit;

    // Candidate k is the requester k positions above rr_ptr, wrapping modulo N.
    for (genvar k = 0; k < N; k++) begin : g_cand
        assign cand[k] = IW'((32'(rr_ptr_q) + k) % N);
    end

    // Scan from the far end so the lowest offset from rr_ptr overwrites the rest.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.req[cand[k]]) begin
                found = 1'b1;
                pick  = cand[k];
            end
        end
    end

    assign next_ptr  = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
    assign owner_req = bus.req[owner_q];

`ifdef TIMER_ARB_WATCHDOG_EN
    localparam int CW = $clog2(WD_LIMIT + 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic [N-1:0]  err_q, err_d;

    assign wd_hit = (wd_cnt_q == CW'(WD_LIMIT - 1));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        err_d    = '0;
        if (state_q == S_ARM) begin
            wd_cnt_d = '0;
        end else if (state_q == S_RUN) begin
            if (!wd_hit) begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
            // Alarm on the limit cycle still reports done, never err.
            if (!bus.tmr_alarm && owner_req && wd_hit) begin
                err_d = grant_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            err_q    <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign wd_hit  = 1'b0;
    assign bus.err = '0;
`endif

    // NOTE: every state element uses non-blocking assignment so all flops update
    // together on the edge; blocking here would leak new values into later reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            tmr_start_q <= 1'b0;
            tmr_up_q    <= 1'b0;
            tmr_const_q <= '0;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            tmr_start_q <= tmr_start_d;
            tmr_up_q    <= tmr_up_d;
            tmr_const_q <= tmr_const_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
        end
    end

    // Alarm is looked at only in RUN; a stale Alarm during START/ARM is ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (found) state_d = S_START;
            S_START: state_d = S_ARM;
            S_ARM:   state_d = S_RUN;
            S_RUN: begin
                if (bus.tmr_alarm)   state_d = S_DONE;
                else if (!owner_req) state_d = S_IDLE;
                else if (wd_hit)     state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: each output starts from a default (hold or zero) before the case,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        grant_d     = grant_q;
        done_d      = '0;
        tmr_start_d = 1'b0;
        tmr_up_d    = tmr_up_q;
        tmr_const_d = tmr_const_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d     = pick;
                    grant_d     = N'(1) << pick;
                    tmr_up_d    = bus.req_up[pick];
                    tmr_const_d = bus.req_const[pick*W +: W];
                    tmr_start_d = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.tmr_alarm) begin
                    done_d = grant_q;
                end else if (!owner_req) begin
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end
            end
            S_DONE: begin
                grant_d  = '0;
                rr_ptr_d = next_ptr;
            end
            default: ;
        endcase
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.tmr_start = tmr_start_q;
    assign bus.tmr_up    = tmr_up_q;
    assign bus.tmr_const = tmr_const_q;
endmodule

// File: tb/tb_timer_arbiter.sv
// Randomised bench for timer_arbiter against a transaction-level reference model.
// Honours TIMER_ARB_WATCHDOG_EN for the watchdog scenario.
module tb_timer_arbiter;
    localparam int N        = 4;
    localparam int W        = 32;
    localparam int WD_LIMIT = 16;
`ifdef TIMER_ARB_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    timer_arbiter_if #(.N(N), .W(W)) bus ();

    timer_arbiter #(.N(N), .W(W), .WD_LIMIT(WD_LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: owner (-1 idle), cycles since grant, RUN length, slot after RUN.
    int           m_owner;
    int           m_age;
    int           m_run;
    int           m_slot;   // 0 none, 1 done slot, 2 err slot
    int           m_ptr;
    logic         m_up;
    logic [W-1:0] m_const;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_run   = 0;
        m_slot  = 0;
        m_ptr   = 0;
        m_up    = 1'b0;
        m_const = '0;
    endtask

    task automatic model_step();
        int p;
        if (m_slot != 0) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_slot  = 0;
        end else if (m_owner < 0) begin
            p = -1;
            for (int k = 0; k < N; k++)
                if (p < 0 && bus.req[(m_ptr + k) % N]) p = (m_ptr + k) % N;
            if (p >= 0) begin
                m_owner = p;
                m_age   = 0;
                m_up    = bus.req_up[p];
                m_const = bus.req_const[p*W +: W];
            end
        end else if (m_age < 2) begin
            m_age++;
            m_run = 0;
        end else if (bus.tmr_alarm) begin
            m_slot = 1;
        end else if (!bus.req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (WD_ON && m_run == WD_LIMIT - 1) begin
            m_slot = 2;
        end else begin
            m_run++;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] eg, ed, ee;
        eg = '0;
        ed = '0;
        ee = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            if (m_slot == 1) ed[m_owner] = 1'b1;
            if (m_slot == 2) ee[m_owner] = 1'b1;
        end
        check("grant", bus.grant, eg);
        check("done", bus.done, ed);
        check("err", bus.err, ee);
        check("busy", bus.busy, m_owner >= 0);
        check("tmr_start", bus.tmr_start, m_owner >= 0 && m_age == 0 && m_slot == 0);
        check("tmr_up", bus.tmr_up, m_up);
        check("tmr_const", bus.tmr_const, m_const);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Called at a falling edge: reset across one rising edge, outputs must clear at once.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_start", bus.tmr_start, 0);
        model_reset();
        compare_all();
        tick();
        rst_n = 1'b1;
    endtask

    int q_owner[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int dcount;
    int quiet;

    initial begin
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.req_up    = '0;
        bus.req_const = '0;
        bus.tmr_alarm = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all();
        tick();
        rst_n = 1'b1;

        // Single requester 1, count down from 5; later constant changes must be ignored.
        bus.req[1]            = 1'b1;
        bus.req_up[1]         = 1'b0;
        bus.req_const[1*W +: W] = 32'd5;
        tick();
        check("t1_grant", bus.grant, 4'b0010);
        check("t1_start", bus.tmr_start, 1);
        check("t1_const", bus.tmr_const, 5);
        bus.req_const[1*W +: W] = 32'd7;
        bus.req_up[1]           = 1'b1;
        tick();
        check("t1_start_low", bus.tmr_start, 0);
        tick();
        bus.tmr_alarm = 1'b1;
        tick();
        check("t1_done", bus.done, 4'b0010);
        check("t1_const_held", bus.tmr_const, 5);
        bus.tmr_alarm = 1'b0;
        bus.req       = '0;
        tick();
        check("t1_done_once", bus.done, 0);
        check("t1_idle", bus.busy, 0);

        // All four request with Alarm stuck high: early Alarm ignored, strict rotation.
        reset_pulse();
        for (int i = 0; i < N; i++) bus.req_const[i*W +: W] = 32'd2;
        bus.req       = '1;
        bus.req_up    = '0;
        bus.tmr_alarm = 1'b1;
        dcount        = 0;
        for (int c = 0; c < 22; c++) begin
            tick();
            if (bus.tmr_start)
                for (int i = 0; i < N; i++) if (bus.grant[i]) q_owner.push_back(i);
            if (|bus.done) dcount++;
        end
        check("rr_grants", q_owner.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < q_owner.size()) check("rr_order", q_owner[i], exp_order[i]);
        check("rr_dones", dcount, 4);

        // Owner 2 in RUN, then reset: abandoned, next search starts at 0.
        reset_pulse();
        bus.tmr_alarm = 1'b0;
        bus.req       = 4'b0100;
        tick();
        tick();
        tick();
        check("mid_owner2", bus.grant, 4'b0100);
        reset_pulse();
        bus.req = '1;
        tick();
        check("rst_from0", bus.grant, 4'b0001);

        // Owner 0 withdraws in RUN: abort, no done, requester 1 served next.
        tick();
        tick();
        bus.req[0] = 1'b0;
        tick();
        check("abort_grant", bus.grant, 0);
        check("abort_done", bus.done, 0);
        tick();
        check("abort_next", bus.grant, 4'b0010);
        bus.req = '0;
        bus.tmr_alarm = 1'b1;
        tick();
        tick();
        tick();
        bus.tmr_alarm = 1'b0;

`ifdef TIMER_ARB_WATCHDOG_EN
        begin
            int  n;
            bit  got_err;
            bit  saw_done;
            reset_pulse();
            bus.req  = 4'b0001;
            tick();
            tick();
            tick();
            n        = 0;
            got_err  = 1'b0;
            saw_done = 1'b0;
            for (int c = 0; c < 40 && !got_err; c++) begin
                tick();
                n++;
                if (|bus.done) saw_done = 1'b1;
                if (|bus.err)  got_err  = 1'b1;
            end
            check("wd_latency", n, WD_LIMIT);
            check("wd_err_owner", bus.err, 4'b0001);
            check("wd_no_done", saw_done, 0);
            bus.req = '0;
            tick();
            tick();
        end
`endif

        // Random traffic: holds, withdrawals, re-requests, stray Alarms, occasional reset.
        quiet = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) reset_pulse();
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    if (bus.done[i] || bus.err[i])       bus.req[i] = 1'($urandom_range(0, 1));
                    else if ($urandom_range(0, 39) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.req[i]    = 1'b1;
                    bus.req_up[i] = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 7) == 0) begin
                    bus.req_const[i*W +: W] = $urandom();
                    bus.req_up[i]           = 1'($urandom_range(0, 1));
                end
            end
            if ($urandom_range(0, 99) == 0) quiet = 30;
            if (quiet > 0) begin
                quiet--;
                bus.tmr_alarm = 1'b0;
            end else begin
                bus.tmr_alarm = ($urandom_range(0, 3) == 0);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
